fp16_mul_seq: RTL and testbench



---
 rtl/fp16_mul_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_fp16_mul_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_seq.sv
// Iterative binary16 multiplier: 11-step shift-add significand product,
// single-cycle normalise, round-to-nearest-even pack; specials bypass the loop.
module fp16_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        SIGN_A,
  input  logic        SIGN_B,
  input  logic [4:0]  IN_EXP_A_HALF,
  input  logic [4:0]  IN_EXP_B_HALF,
  input  logic [10:0] IN_MANT_A_HALF,
  input  logic [10:0] IN_MANT_B_HALF,
  input  logic [9:0]  MANTISSA_DECODE_A,
  input  logic [9:0]  MANTISSA_DECODE_B,
  output logic [15:0] Q,
  output logic [4:0]  flags,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [21:0]        acc_q, acc_d;
  logic [10:0]        mcand_q, mcand_d;
  logic [10:0]        mplier_q, mplier_d;
  logic signed [7:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               sticky_q, sticky_d;
  logic [15:0]        q_q, q_d;
  logic [4:0]         flags_q, flags_d;

  // Operand classification on the raw input fields
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, exc;
  logic [15:0] exc_q;
  logic [7:0]  ea_eff, eb_eff;

  always_comb begin
    nan_a  = (&IN_EXP_A_HALF) && (|MANTISSA_DECODE_A);
    nan_b  = (&IN_EXP_B_HALF) && (|MANTISSA_DECODE_B);
    inf_a  = (&IN_EXP_A_HALF) && !(|MANTISSA_DECODE_A);
    inf_b  = (&IN_EXP_B_HALF) && !(|MANTISSA_DECODE_B);
    zero_a = !(|IN_EXP_A_HALF) && !(|MANTISSA_DECODE_A);
    zero_b = !(|IN_EXP_B_HALF) && !(|MANTISSA_DECODE_B);
    exc    = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      exc_q = 16'h7E00;
    else if (inf_a || inf_b)
      exc_q = {SIGN_A ^ SIGN_B, 5'h1F, 10'h000};
    else
      exc_q = {SIGN_A ^ SIGN_B, 15'h0000};
    ea_eff = (IN_EXP_A_HALF == 5'd0) ? 8'd1 : {3'b000, IN_EXP_A_HALF};
    eb_eff = (IN_EXP_B_HALF == 5'd0) ? 8'd1 : {3'b000, IN_EXP_B_HALF};
  end

  // Normalisation: one right shift on a 2.x product, otherwise left shift
  // bounded by E=1, then a denormalising right shift when E < 1.
  logic [21:0]  norm_m;
  logic [31:0]  norm_ext;
  logic         norm_st;
  logic [7:0]   norm_e;
  int           ne, nsh, nrsh;
  int unsigned  lz;

  always_comb begin
    norm_m   = acc_q;
    norm_st  = 1'b0;
    norm_ext = '0;
    ne       = int'(exp_q);
    nsh      = 0;
    nrsh     = 0;
    lz       = 21;
    if (norm_m[21]) begin
      norm_st = norm_m[0];
      norm_m  = norm_m >> 1;
      ne      = ne + 1;
    end else begin
      for (int unsigned i = 0; i < 21; i++)
        if (norm_m[i]) lz = 20 - i;
      if (ne > 1) begin
        nsh    = (int'(lz) < ne - 1) ? int'(lz) : ne - 1;
        norm_m = norm_m << nsh;
        ne     = ne - nsh;
      end
    end
    if (ne < 1) begin
      nrsh     = 1 - ne;
      if (nrsh > 24) nrsh = 24;
      norm_ext = {10'b0, norm_m};
      norm_st  = norm_st | (|(norm_ext & ((32'd1 << nrsh) - 32'd1)));
      norm_m   = 22'(norm_ext >> nrsh);
      ne       = 0;
    end
    norm_e = 8'(ne);
  end

  // Rounding and packing of the normalised significand (hidden bit at 20)
  logic        rg, rr, rs, inx, rnd;
  logic [11:0] mant12;
  logic [4:0]  expf;
  logic [15:0] pack_q;
  logic [4:0]  pack_f;
  int          pe;

  always_comb begin
    rg     = acc_q[9];
    rr     = acc_q[8];
    rs     = (|acc_q[7:0]) | sticky_q;
    inx    = rg | rr | rs;
    rnd    = rg & (rr | rs | acc_q[10]);
    mant12 = {1'b0, acc_q[20:10]} + {11'b0, rnd};
    pe     = int'(exp_q);
    expf   = '0;
    if (mant12[11]) begin
      mant12 = mant12 >> 1;
      pe     = pe + 1;
    end else if (pe == 0 && mant12[10]) begin
      pe = 1;
    end
    if (pe >= 31) begin
      pack_q = {sign_q, 5'h1F, 10'h000};
      pack_f = 5'b00101;
    end else begin
      expf   = mant12[10] ? 5'(pe) : 5'd0;
      pack_q = {sign_q, expf, mant12[9:0]};
      pack_f = {3'b000, (expf == 5'd0) & inx, inx};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    q_d      = q_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d   = SIGN_A ^ SIGN_B;
          mcand_d  = IN_MANT_A_HALF;
          mplier_d = IN_MANT_B_HALF;
          exp_d    = ea_eff + eb_eff - 8'd15;
          cnt_d    = '0;
          acc_d    = '0;
          sticky_d = 1'b0;
          if (exc) begin
            q_d     = exc_q;
            flags_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[cnt_q])
          acc_d = acc_q + ({11'b0, mcand_q} << cnt_q);
        if (cnt_q == 4'd10) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_NORM: begin
        acc_d    = norm_m;
        exp_d    = norm_e;
        sticky_d = norm_st;
        state_d  = S_PACK;
      end
      S_PACK: begin
        q_d     = pack_q;
        flags_d = pack_f;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      q_q      <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      q_q      <= q_d;
      flags_q  <= flags_d;
    end
  end

  assign Q     = q_q;
  assign flags = flags_q;
  assign busy  = (state_q == S_MUL) || (state_q == S_NORM) || (state_q == S_PACK);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Scoreboard bench for fp16_mul_seq: directed vectors with hand-computed results.
module tb_fp16_mul_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        SIGN_A, SIGN_B;
  logic [4:0]  IN_EXP_A_HALF, IN_EXP_B_HALF;
  logic [10:0] IN_MANT_A_HALF, IN_MANT_B_HALF;
  logic [9:0]  MANTISSA_DECODE_A, MANTISSA_DECODE_B;
  logic [15:0] Q;
  logic [4:0]  flags;
  logic        busy, done;

  fp16_mul_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .SIGN_A(SIGN_A), .SIGN_B(SIGN_B),
    .IN_EXP_A_HALF(IN_EXP_A_HALF), .IN_EXP_B_HALF(IN_EXP_B_HALF),
    .IN_MANT_A_HALF(IN_MANT_A_HALF), .IN_MANT_B_HALF(IN_MANT_B_HALF),
    .MANTISSA_DECODE_A(MANTISSA_DECODE_A), .MANTISSA_DECODE_B(MANTISSA_DECODE_B),
    .Q(Q), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [4:0]  f;
    int          acc;
    int          lat;
    int          bcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    SIGN_A            = a[15];
    SIGN_B            = b[15];
    IN_EXP_A_HALF     = a[14:10];
    IN_EXP_B_HALF     = b[14:10];
    MANTISSA_DECODE_A = a[9:0];
    MANTISSA_DECODE_B = b[9:0];
    IN_MANT_A_HALF    = {(a[14:10] != 5'd0), a[9:0]};
    IN_MANT_B_HALF    = {(b[14:10] != 5'd0), b[9:0]};
  endtask

  task automatic push_exp(input logic [15:0] q, input logic [4:0] f, input int acc, input bit exc);
    exp_t e;
    e.q    = q;
    e.f    = f;
    e.acc  = acc;
    e.lat  = exc ? 1 : 14;
    e.bcnt = exc ? 0 : 13;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk(name, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [4:0] f, input bit exc);
    @(negedge clk);
    set_ops(a, b);
    start = 1'b1;
    @(posedge clk);
    push_exp(q, f, cyc, exc);
    #1 start = 1'b0;
    wait_drain("timeout");
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("Q", 32'(Q), 32'(e.q));
          chk("flags", 32'(flags), 32'(e.f));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.bcnt));
          chk("busy_in_done", 32'(busy), 32'd0);
        end
      end
      if (!busy && !done) busy_cnt = 0;
    end
  end

  initial begin
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    set_ops(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_Q", 32'(Q), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    run_op(16'h3E00, 16'h4000, 16'h4200, 5'b00000, 1'b0);
    run_op(16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00101, 1'b0);
    run_op(16'h7C00, 16'h0000, 16'h7E00, 5'b00000, 1'b1);
    run_op(16'h0001, 16'h3C00, 16'h0001, 5'b00000, 1'b0);
    run_op(16'h0001, 16'h3800, 16'h0000, 5'b00011, 1'b0);
    run_op(16'h7E01, 16'h3C00, 16'h7E00, 5'b00000, 1'b1);
    run_op(16'h7C00, 16'hC000, 16'hFC00, 5'b00000, 1'b1);
    run_op(16'h0000, 16'h8001, 16'h8000, 5'b00000, 1'b1);
    run_op(16'h3C01, 16'h3C01, 16'h3C02, 5'b00001, 1'b0);
    run_op(16'h3C01, 16'h3E00, 16'h3E02, 5'b00001, 1'b0);
    run_op(16'h3C03, 16'h3E00, 16'h3E04, 5'b00001, 1'b0);
    run_op(16'h0001, 16'h6400, 16'h0400, 5'b00000, 1'b0);

    // start held high: accepts at edges 0 and 15 only; inputs disturbed mid-MUL
    @(negedge clk);
    set_ops(16'h3C00, 16'hC000);
    start = 1'b1;
    @(posedge clk);
    c0 = cyc;
    push_exp(16'hC000, 5'b00000, c0, 1'b0);
    push_exp(16'hC000, 5'b00000, c0 + 15, 1'b0);
    repeat (3) @(negedge clk);
    set_ops(16'h7BFF, 16'h7BFF);
    repeat (6) @(negedge clk);
    set_ops(16'h3C00, 16'hC000);
    repeat (21) @(negedge clk);
    start = 1'b0;
    wait_drain("hold_timeout");

    // reset during MUL cycle 6 discards the operation
    @(negedge clk);
    set_ops(16'h3C00, 16'h4000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_Q", 32'(Q), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_op(16'h3C00, 16'h4000, 16'h4000, 5'b00000, 1'b0);

    // rst and start together: start dropped
    @(negedge clk);
    set_ops(16'h3C00, 16'h3C00);
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("rststart_busy", 32'(busy), 32'd0);
    chk("rststart_done", 32'(done), 32'd0);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
